// File: rtl/adder_stim_checker.sv
// ============================================================================
// Module   : adder_stim_checker
// Brief    : On-chip sweep stimulus and result checker for a WIDTH-bit adder.
//            Optional FAIL_CAPTURE_EN records the first failing vector/sum.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module adder_stim_checker #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic [2*WIDTH-1:0]   stim_out,
    input  logic [WIDTH:0]       dut_sum,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [7:0]           err_count
`ifdef FAIL_CAPTURE_EN
    ,
    output logic [2*WIDTH-1:0]   first_fail_vec,
    output logic [WIDTH:0]       first_fail_sum,
    output logic                 fail_valid
`endif
);

    localparam int                 c_VEC_W    = 2*WIDTH + 1;
    localparam logic [c_VEC_W-1:0] c_LAST_VEC = {1'b0, {(2*WIDTH){1'b1}}};
    localparam logic [3:0]         c_SETTLE   = SETTLE[3:0];

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]          r_state;
    logic [2:0]          w_state_nxt;
    logic                w_accept;
    logic [c_VEC_W-1:0]  r_vec;
    logic [3:0]          r_settle;
    logic [2*WIDTH-1:0]  r_stim;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic [7:0]          r_err;
    logic [7:0]          w_err_nxt;
    logic [WIDTH:0]      w_ref;
    logic                w_mismatch;
    logic                w_last;

    // Reference is taken from the driven bus so it always matches what the DUT sees
    assign w_ref      = {1'b0, r_stim[2*WIDTH-1:WIDTH]} + {1'b0, r_stim[WIDTH-1:0]};
    assign w_mismatch = (dut_sum != w_ref);
    assign w_last     = (r_vec == c_LAST_VEC);

    always_comb begin
        w_err_nxt = r_err;
        if (w_mismatch && (r_err != 8'hFF)) begin
            w_err_nxt = r_err + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nxt = S_DRIVE;
                    w_accept    = 1'b1;
                end
            end
            S_DRIVE: w_state_nxt = (c_SETTLE != 4'd0) ? S_WAIT : S_CHECK;
            S_WAIT: begin
                if (r_settle <= 4'd1) begin
                    w_state_nxt = S_CHECK;
                end
            end
            S_CHECK: w_state_nxt = w_last ? S_DONE : S_DRIVE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vec    <= '0;
            r_settle <= '0;
            r_stim   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_pass   <= 1'b0;
            r_err    <= '0;
        end else begin
            if (w_accept) begin
                r_vec  <= '0;
                r_err  <= '0;
                r_busy <= 1'b1;
                r_done <= 1'b0;
                r_pass <= 1'b0;
            end
            case (r_state)
                S_DRIVE: begin
                    r_stim   <= r_vec[2*WIDTH-1:0];
                    r_settle <= c_SETTLE;
                end
                S_WAIT: r_settle <= r_settle - 4'd1;
                S_CHECK: begin
                    r_err <= w_err_nxt;
                    if (w_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                        r_pass <= (w_err_nxt == 8'd0);
                    end else begin
                        r_vec <= r_vec + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FAIL_CAPTURE_EN
    logic [2*WIDTH-1:0] r_ff_vec;
    logic [WIDTH:0]     r_ff_sum;
    logic               r_ff_valid;

    // Only the first mismatch of a sweep is kept
    always_ff @(posedge clk) begin
        if (rst || w_accept) begin
            r_ff_vec   <= '0;
            r_ff_sum   <= '0;
            r_ff_valid <= 1'b0;
        end else if ((r_state == S_CHECK) && w_mismatch && !r_ff_valid) begin
            r_ff_vec   <= r_stim;
            r_ff_sum   <= dut_sum;
            r_ff_valid <= 1'b1;
        end
    end

    assign first_fail_vec = r_ff_vec;
    assign first_fail_sum = r_ff_sum;
    assign fail_valid     = r_ff_valid;
`endif

    assign stim_out  = r_stim;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_adder_stim_checker.sv
// ============================================================================
// Module   : tb_adder_stim_checker
// Brief    : Scoreboard bench: a modelled (optionally faulty) adder is swept by
//            the checker; expected sweep results come from plain arithmetic.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_adder_stim_checker;

    localparam int WIDTH  = 4;
    localparam int SETTLE = 1;
    localparam int NVEC   = 256;
    localparam int SWEEP  = NVEC * (SETTLE + 2);

    typedef struct {
        int err;
        int pass;
        int cycles;
        int valid;
        int vec;
        int sum;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] stim_out;
    logic [4:0] dut_sum;
    logic       busy, done, pass;
    logic [7:0] err_count;
`ifdef FAIL_CAPTURE_EN
    logic [7:0] first_fail_vec;
    logic [4:0] first_fail_sum;
    logic       fail_valid;
`endif

    int   total = 0;
    int   bad   = 0;
    int   mode  = 0;
    logic [4:0] fmask [NVEC];
    exp_t sb [$];

    adder_stim_checker #(.WIDTH(WIDTH), .SETTLE(SETTLE)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stim_out  (stim_out),
        .dut_sum   (dut_sum),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .err_count (err_count)
`ifdef FAIL_CAPTURE_EN
        ,
        .first_fail_vec (first_fail_vec),
        .first_fail_sum (first_fail_sum),
        .fail_valid     (fail_valid)
`endif
    );

    always #5 clk = ~clk;

    // Adder under test: 0 good, 1 sum[0] stuck 0, 2 constant 0x1F, 3 no carry, 4 random faults
    function automatic logic [4:0] model_out(input int m, input logic [7:0] v, input logic [4:0] mask);
        int s;
        s = int'(v[7:4]) + int'(v[3:0]);
        case (m)
            0:       return 5'(s);
            1:       return 5'(s & 30);
            2:       return 5'h1F;
            3:       return 5'(s & 15);
            default: return 5'(s) ^ mask;
        endcase
    endfunction

    assign dut_sum = model_out(mode, stim_out, fmask[stim_out]);

    function automatic exp_t predict();
        exp_t e;
        int   cnt;
        logic [4:0] got;
        logic [7:0] v8;
        cnt = 0;
        e.valid = 0; e.vec = 0; e.sum = 0;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                v8  = 8'(a * 16 + b);
                got = model_out(mode, v8, fmask[v8]);
                if (int'(got) != a + b) begin
                    if (e.valid == 0) begin
                        e.valid = 1; e.vec = a * 16 + b; e.sum = int'(got);
                    end
                    cnt++;
                end
            end
        end
        e.err    = (cnt > 255) ? 255 : cnt;
        e.pass   = (cnt == 0) ? 1 : 0;
        e.cycles = SWEEP;
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: counts busy cycles and scores each completed sweep
    initial begin
        int   busy_cnt;
        logic prev_done;
        exp_t e;
        busy_cnt  = 0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                busy_cnt  = 0;
                prev_done = 1'b0;
            end else begin
                if (busy) busy_cnt++;
                if (done && !prev_done) begin
                    check("sb_pending", (sb.size() > 0) ? 1 : 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("err_count", int'(err_count), e.err);
                        check("pass", int'(pass), e.pass);
                        check("busy_cycles", busy_cnt, e.cycles);
`ifdef FAIL_CAPTURE_EN
                        check("fail_valid", int'(fail_valid), e.valid);
                        if (e.valid != 0) begin
                            check("first_fail_vec", int'(first_fail_vec), e.vec);
                            check("first_fail_sum", int'(first_fail_sum), e.sum);
                        end
`endif
                    end
                    busy_cnt = 0;
                end
                prev_done = done;
            end
        end
    end

    task automatic set_faults(input int pct);
        for (int i = 0; i < NVEC; i++) begin
            fmask[i] = ($urandom_range(0, 99) < pct) ? 5'($urandom_range(1, 31)) : 5'd0;
        end
    endtask

    task automatic run_sweep(input int m, input int ignore_at);
        exp_t e;
        int   c;
        mode = m;
        e = predict();
        sb.push_back(e);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_busy", int'(busy), 1);
        check("start_done", int'(done), 0);
        check("start_pass", int'(pass), 0);
        check("start_err", int'(err_count), 0);
`ifdef FAIL_CAPTURE_EN
        check("start_fail_valid", int'(fail_valid), 0);
`endif
        c = 1;
        while (!done && c < SWEEP + 50) begin
            if (c == ignore_at) start = 1'b1;
            tick();
            start = 1'b0;
            c++;
        end
        check("done_seen", int'(done), 1);
        tick();
        check("end_stim", int'(stim_out), 255);
        check("end_busy", int'(busy), 0);
        check("hold_done", int'(done), 1);
    endtask

    initial begin
        for (int i = 0; i < NVEC; i++) fmask[i] = 5'd0;
        rst = 1'b1;
        repeat (3) tick();
        check("rst_stim", int'(stim_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_pass", int'(pass), 0);
        check("rst_err", int'(err_count), 0);
        rst = 1'b0;
        tick();

        run_sweep(0, 100);
        run_sweep(1, 0);
        run_sweep(2, 0);
        run_sweep(3, $urandom_range(2, 700));
        set_faults(0);   run_sweep(4, 0);
        set_faults(5);   run_sweep(4, 0);
        set_faults(50);  run_sweep(4, 0);
        set_faults(100); run_sweep(4, 0);

        // Abort mid-sweep with rst and start together
        mode = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (298) tick();
        rst = 1'b1;
        start = 1'b1;
        tick();
        check("abort_stim", int'(stim_out), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_done", int'(done), 0);
        check("abort_pass", int'(pass), 0);
        check("abort_err", int'(err_count), 0);
        rst = 1'b0;
        start = 1'b0;
        tick();
        check("abort_idle_busy", int'(busy), 0);
        check("abort_idle_done", int'(done), 0);

        set_faults(3);
        run_sweep(4, 0);
        run_sweep(0, 0);

        tick();
        check("sb_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
